match_scorer: RTL



---
 rtl/match_scorer_if.sv | 24 ++
 rtl/match_scorer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/match_scorer_if.sv
// Signal bundle between the match scorer, the playfield LED chain and the HEX displays.
// The master side drives the play inputs; the slave side (the scorer) drives the results.
interface match_scorer_if;
    logic       L;
    logic       R;
    logic       L_endLED;
    logic       R_endLED;
    logic       new_match;
    logic       field_reset;
    logic       match_over;
    logic [6:0] HEX_L;
    logic [6:0] HEX_R;
    logic [6:0] HEX_W;

    modport master (
        output L, R, L_endLED, R_endLED, new_match,
        input  field_reset, match_over, HEX_L, HEX_R, HEX_W
    );

    modport slave (
        input  L, R, L_endLED, R_endLED, new_match,
        output field_reset, match_over, HEX_L, HEX_R, HEX_W
    );
endinterface

// File: rtl/match_scorer.sv
// Best-of match tracker for the tug-of-war playfield: counts round wins, holds the field after each round.
// Optional macro MATCH_WIN_BY_TWO_EN: the match closes only with a two-round lead (or a score of 9).
module match_scorer #(
    parameter int WIN_ROUNDS  = 3,
    parameter int HOLD_CYCLES = 8
) (
    input  logic          clk,
    input  logic          reset,
    match_scorer_if.slave bus
);
    typedef enum logic [1:0] {PLAY, HOLD, DONE} state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] MAX_SCORE = 4'd9;

    state_t     r_state, w_state;
    logic [3:0] r_score_l, r_score_r, w_score_l, w_score_r;
    logic [7:0] r_hold_cnt, w_hold_cnt;
    logic       r_left_won, w_left_won;
    logic       r_field_reset, r_match_over;
    logic [6:0] r_hex_l, r_hex_r, r_hex_w, w_hex_w;
    logic       w_lwin, w_rwin, w_close;
    logic [3:0] w_win_score;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= MAX_SCORE) ? MAX_SCORE : s + 4'd1;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    assign w_lwin = bus.L & ~bus.R & bus.L_endLED & ~bus.R_endLED;
    assign w_rwin = ~bus.L & bus.R & ~bus.L_endLED & bus.R_endLED;

    // During HOLD the registered scores already include the round just won.
    assign w_win_score = r_left_won ? r_score_l : r_score_r;

`ifdef MATCH_WIN_BY_TWO_EN
    logic [3:0]        w_lose_score;
    logic signed [5:0] w_lead;
    assign w_lose_score = r_left_won ? r_score_r : r_score_l;
    assign w_lead       = $signed({2'b00, w_win_score}) - $signed({2'b00, w_lose_score});
    assign w_close      = (w_win_score >= 4'(WIN_ROUNDS)) &&
                          ((w_lead >= 6'sd2) || (w_win_score == MAX_SCORE));
`else
    assign w_close = (w_win_score == 4'(WIN_ROUNDS));
`endif

    always_comb begin
        w_state    = r_state;
        w_score_l  = r_score_l;
        w_score_r  = r_score_r;
        w_hold_cnt = r_hold_cnt;
        w_left_won = r_left_won;
        if (bus.new_match) begin
            w_state    = PLAY;
            w_score_l  = '0;
            w_score_r  = '0;
            w_hold_cnt = '0;
        end else begin
            unique case (r_state)
                PLAY: begin
                    if (w_lwin) begin
                        w_score_l  = sat_inc(r_score_l);
                        w_left_won = 1'b1;
                        w_state    = HOLD;
                        w_hold_cnt = '0;
                    end else if (w_rwin) begin
                        w_score_r  = sat_inc(r_score_r);
                        w_left_won = 1'b0;
                        w_state    = HOLD;
                        w_hold_cnt = '0;
                    end
                end
                HOLD: begin
                    w_hold_cnt = r_hold_cnt + 8'd1;
                    if (r_hold_cnt == 8'(HOLD_CYCLES - 1)) begin
                        w_state = w_close ? DONE : PLAY;
                    end
                end
                DONE: begin
                end
                default: w_state = PLAY;
            endcase
        end
    end

    // The match winner is always the winner of the last round, so one digit serves HOLD and DONE.
    always_comb begin
        w_hex_w = SEG_BLANK;
        if (w_state != PLAY) begin
            w_hex_w = seg7(w_left_won ? 4'd2 : 4'd1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= PLAY;
            r_score_l     <= '0;
            r_score_r     <= '0;
            r_hold_cnt    <= '0;
            r_left_won    <= 1'b0;
            r_field_reset <= 1'b0;
            r_match_over  <= 1'b0;
            r_hex_l       <= 7'b1000000;
            r_hex_r       <= 7'b1000000;
            r_hex_w       <= SEG_BLANK;
        end else begin
            r_state       <= w_state;
            r_score_l     <= w_score_l;
            r_score_r     <= w_score_r;
            r_hold_cnt    <= w_hold_cnt;
            r_left_won    <= w_left_won;
            r_field_reset <= (w_state != PLAY);
            r_match_over  <= (w_state == DONE);
            r_hex_l       <= seg7(w_score_l);
            r_hex_r       <= seg7(w_score_r);
            r_hex_w       <= w_hex_w;
        end
    end

    assign bus.field_reset = r_field_reset;
    assign bus.match_over  = r_match_over;
    assign bus.HEX_L       = r_hex_l;
    assign bus.HEX_R       = r_hex_r;
    assign bus.HEX_W       = r_hex_w;
endmodule
